vga_scan_ctrl: RTL and testbench

//  Raster/timing end of the VGA colour framebuffer. Generates 640x480@60 timing from a 25 MHz pixel clock
//  and drives pixel coordinates (160x120 space, 4x4 replicated) into the framebuffer read port.

---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_counter.sv | 54 +++++
 rtl/vga_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_vga_scan_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared timing constants, the 12-bit RGB type and the fixed
//               16-entry CGA-order palette used by the VGA scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // 640x480@60 timing, 25 MHz pixel clock
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // log2 of the pixel replication factor (640>>2 = 160, 480>>2 = 120)
  localparam int SCALE_SHIFT = 2;
  // Raster counter width
  localparam int CNT_W = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // CGA ordering; entry 6 is the "brown" special case (A50, not AA0)
  localparam rgb12_t PALETTE [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_counter
// Description : Horizontal/vertical raster counter. hcnt runs 0..H_TOT-1 and
//               wraps; vcnt advances only on that wrap and itself wraps at
//               V_TOT-1.
// Ports       : i_clk  - pixel clock
//               i_rst  - synchronous active-high reset (counters to 0,0)
//               o_hcnt - current horizontal position
//               o_vcnt - current vertical position
// Revision    : 1.0 - initial release
// ============================================================================
module vga_counter
  import vga_pkg::*;
#(
  parameter int H_TOT = H_TOTAL,
  parameter int V_TOT = V_TOTAL
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [CNT_W-1:0] o_hcnt,
  output logic [CNT_W-1:0] o_vcnt
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q + CNT_W'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign o_hcnt = hcnt_q;
  assign o_vcnt = vcnt_q;

endmodule : vga_counter
`default_nettype wire

// File: rtl/vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_ctrl
// Description : VGA raster/timing end of the colour framebuffer. Generates
//               the scan position, addresses the framebuffer in the 4x4
//               replicated 160x120 space, maps the returned colour index
//               through the palette and emits RGB and syncs, all two cycles
//               after the counter position they belong to.
// Ports       : i_clk        - pixel clock (shared with framebuffer read port)
//               i_rst        - synchronous active-high reset
//               o_pxlX/o_pxlY- framebuffer read coordinates (stage 0)
//               i_value      - colour index, valid one cycle after o_pxlX/Y
//               o_red/green/blue - 12-bit RGB, black outside the visible area
//               o_hsync/o_vsync  - active-low syncs
//               o_vblank     - high during non-visible output lines
//               o_frameStart - one-cycle pulse with the RGB of pixel (0,0)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int H_VIS = H_VISIBLE,
  parameter int H_FP  = H_FRONT,
  parameter int H_SW  = H_SYNC,
  parameter int H_BP  = H_BACK,
  parameter int V_VIS = V_VISIBLE,
  parameter int V_FP  = V_FRONT,
  parameter int V_SW  = V_SYNC,
  parameter int V_BP  = V_BACK,
  parameter int SHIFT = SCALE_SHIFT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [7:0] o_pxlX,
  output logic [7:0] o_pxlY,
  input  logic [3:0] i_value,
  output logic [3:0] o_red,
  output logic [3:0] o_green,
  output logic [3:0] o_blue,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_vblank,
  output logic       o_frameStart
);

  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

  localparam logic [CNT_W-1:0] H_VIS_C    = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_VIS + H_FP + H_SW);
  localparam logic [CNT_W-1:0] V_VIS_C    = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_VIS + V_FP + V_SW);

  // ---------------- Stage 0: raster position ----------------
  logic [CNT_W-1:0] hcnt, vcnt;

  vga_counter #(
    .H_TOT (H_TOT),
    .V_TOT (V_TOT)
  ) u_counter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_hcnt (hcnt),
    .o_vcnt (vcnt)
  );

  logic h_vis, v_vis, vis, hs, vs, fs;

  assign h_vis = (hcnt < H_VIS_C);
  assign v_vis = (vcnt < V_VIS_C);
  assign vis   = h_vis && v_vis;
  assign hs    = (hcnt >= HS_START_C) && (hcnt < HS_END_C);
  assign vs    = (vcnt >= VS_START_C) && (vcnt < VS_END_C);
  assign fs    = (hcnt == '0) && (vcnt == '0);

  // Coordinates are parked at 0 in blanking so the buffer never sees an
  // out-of-range address; the returned index is ignored there anyway.
  assign o_pxlX = h_vis ? 8'(hcnt >> SHIFT) : 8'd0;
  assign o_pxlY = v_vis ? 8'(vcnt >> SHIFT) : 8'd0;

  // ---------------- Stage 1: travels with the buffer read ----------------
  logic vis1_q, hs1_q, vs1_q, fs1_q, vb1_q;

  // ---------------- Stage 2: output registers ----------------
  rgb12_t rgb_q;
  logic   hsync_n_q, vsync_n_q, fs2_q, vblank_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vis1_q    <= 1'b0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      fs1_q     <= 1'b0;
      vb1_q     <= 1'b0;
      rgb_q     <= '0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      fs2_q     <= 1'b0;
      vblank_q  <= 1'b0;
    end else begin
      vis1_q    <= vis;
      hs1_q     <= hs;
      vs1_q     <= vs;
      fs1_q     <= fs;
      vb1_q     <= ~v_vis;
      // Blanking forces black regardless of whatever index the buffer returns
      rgb_q     <= vis1_q ? PALETTE[i_value] : '0;
      hsync_n_q <= ~hs1_q;
      vsync_n_q <= ~vs1_q;
      fs2_q     <= fs1_q;
      vblank_q  <= vb1_q;
    end
  end

  assign o_red        = rgb_q.r;
  assign o_green      = rgb_q.g;
  assign o_blue       = rgb_q.b;
  assign o_hsync      = hsync_n_q;
  assign o_vsync      = vsync_n_q;
  assign o_vblank     = vblank_q;
  assign o_frameStart = fs2_q;

endmodule : vga_scan_ctrl
`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scan_ctrl
// Description : Testbench for vga_scan_ctrl. One instance at full 640x480
//               timing and one with a shrunken raster so whole frames fit.
//               Expected outputs come from raster arithmetic on the number of
//               cycles since reset release and a framebuffer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_ctrl;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst  = 1'b1;
  int   mode = 0;  // 0: random framebuffer, 1: index A at column 1, 2: constant F

  // Full-timing DUT
  logic [7:0] px0, py0;
  logic [3:0] v0, r0, g0, b0;
  logic       hs0, vs0, vb0, fs0;
  // Shrunken-raster DUT (80x55 total, 64x48 visible)
  logic [7:0] px1, py1;
  logic [3:0] v1, r1, g1, b1;
  logic       hs1, vs1, vb1, fs1;

  vga_scan_ctrl u_dut (
    .i_clk(clk), .i_rst(rst), .o_pxlX(px0), .o_pxlY(py0), .i_value(v0),
    .o_red(r0), .o_green(g0), .o_blue(b0), .o_hsync(hs0), .o_vsync(vs0),
    .o_vblank(vb0), .o_frameStart(fs0)
  );

  vga_scan_ctrl #(
    .H_VIS(64), .H_FP(4), .H_SW(8), .H_BP(4),
    .V_VIS(48), .V_FP(2), .V_SW(2), .V_BP(3), .SHIFT(2)
  ) u_small (
    .i_clk(clk), .i_rst(rst), .o_pxlX(px1), .o_pxlY(py1), .i_value(v1),
    .o_red(r1), .o_green(g1), .o_blue(b1), .o_hsync(hs1), .o_vsync(vs1),
    .o_vblank(vb1), .o_frameStart(fs1)
  );

  int HV[2] = '{640, 64};
  int HF[2] = '{16, 4};
  int HS[2] = '{96, 8};
  int HT[2] = '{800, 80};
  int VV[2] = '{480, 48};
  int VF[2] = '{10, 2};
  int VS[2] = '{2, 2};
  int VT[2] = '{525, 55};

  logic [3:0] fbmem [0:119][0:159];

  function automatic logic [3:0] fb(int m, int x, int y);
    case (m)
      0:       return (x < 160 && y < 120) ? fbmem[y][x] : 4'h0;
      1:       return (x == 1) ? 4'hA : 4'h0;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [11:0] pal(logic [3:0] i);
    case (i)
      4'h0: return 12'h000;  4'h1: return 12'h00A;
      4'h2: return 12'h0A0;  4'h3: return 12'h0AA;
      4'h4: return 12'hA00;  4'h5: return 12'hA0A;
      4'h6: return 12'hA50;  4'h7: return 12'hAAA;
      4'h8: return 12'h555;  4'h9: return 12'h55F;
      4'hA: return 12'h5F5;  4'hB: return 12'h5FF;
      4'hC: return 12'hF55;  4'hD: return 12'hF5F;
      4'hE: return 12'hFF5;  default: return 12'hFFF;
    endcase
  endfunction

  // Framebuffer read ports: one-cycle registered lookup
  always @(posedge clk) begin
    v0 <= fb(mode, int'(px0), int'(py0));
    v1 <= fb(mode, int'(px1), int'(py1));
  end

  typedef struct packed {
    int         n;
    logic [7:0] px;
    logic [7:0] py;
    logic [11:0] rgb;
    logic       hs;
    logic       vs;
    logic       vb;
    logic       fs;
  } obs_t;

  // Expected pins in the cycle that is n cycles after the last reset edge;
  // m2 is the buffer mode two cycles earlier, when that pixel was fetched.
  function automatic obs_t exp_obs(int d, int n, int m2);
    obs_t e;
    int hc, vc, p;
    e.n  = n;
    hc   = n % HT[d];
    vc   = (n / HT[d]) % VT[d];
    e.px = (hc < HV[d]) ? 8'(hc / 4) : 8'd0;
    e.py = (vc < VV[d]) ? 8'(vc / 4) : 8'd0;
    if (n < 2) begin
      e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1; e.vb = 1'b0; e.fs = 1'b0;
    end else begin
      p     = n - 2;
      hc    = p % HT[d];
      vc    = (p / HT[d]) % VT[d];
      e.rgb = (hc < HV[d] && vc < VV[d]) ? pal(fb(m2, hc / 4, vc / 4)) : 12'h000;
      e.hs  = !(hc >= HV[d] + HF[d] && hc < HV[d] + HF[d] + HS[d]);
      e.vs  = !(vc >= VV[d] + VF[d] && vc < VV[d] + VF[d] + VS[d]);
      e.vb  = !(vc < VV[d]);
      e.fs  = (p % (HT[d] * VT[d])) == 0;
    end
    return e;
  endfunction

  int   n_cyc   = 0;
  bit   started = 1'b0;
  int   checks  = 0;
  int   failures = 0;
  obs_t q0[$], q1[$];
  int   mhist[$];

  always @(posedge clk) begin
    n_cyc   <= rst ? 0 : n_cyc + 1;
    started <= 1'b1;
  end

  // Reference model: pushes one expected observation per cycle per DUT
  initial forever begin
    @(negedge clk);
    if (started) begin
      mhist.push_back(mode);
      if (mhist.size() > 3) void'(mhist.pop_front());
      q0.push_back(exp_obs(0, n_cyc, mhist[0]));
      q1.push_back(exp_obs(1, n_cyc, mhist[0]));
    end
  end

  task automatic cmp(string nm, obs_t a, obs_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s n=%0d actual px=%0d py=%0d rgb=%03h hs=%b vs=%b vb=%b fs=%b required px=%0d py=%0d rgb=%03h hs=%b vs=%b vb=%b fs=%b",
               nm, e.n, a.px, a.py, a.rgb, a.hs, a.vs, a.vb, a.fs,
               e.px, e.py, e.rgb, e.hs, e.vs, e.vb, e.fs);
    end
  endtask

  task automatic cmp_phase(string nm, int actual, int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s actual_phase=%0d required_phase=%0d", nm, actual, required);
    end
  endtask

  // Monitor: pops and compares every cycle, plus edge-timing checks
  initial begin
    obs_t e, a;
    logic p_hs0 = 1'b1, p_vs1 = 1'b1, p_fs1 = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        a = '{n: e.n, px: px0, py: py0, rgb: {r0, g0, b0}, hs: hs0, vs: vs0, vb: vb0, fs: fs0};
        cmp("full_pins", a, e);
        if (p_hs0 === 1'b1 && hs0 === 1'b0) cmp_phase("hsync_fall", e.n % 800, 658);
        if (p_hs0 === 1'b0 && hs0 === 1'b1) cmp_phase("hsync_rise", e.n % 800, 754);
        p_hs0 = hs0;
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a = '{n: e.n, px: px1, py: py1, rgb: {r1, g1, b1}, hs: hs1, vs: vs1, vb: vb1, fs: fs1};
        cmp("small_pins", a, e);
        if (p_vs1 === 1'b1 && vs1 === 1'b0) cmp_phase("vsync_fall", e.n % 4400, 4002);
        if (p_vs1 === 1'b0 && vs1 === 1'b1) cmp_phase("vsync_rise", e.n % 4400, 4162);
        if (p_fs1 === 1'b0 && fs1 === 1'b1) cmp_phase("frame_start", e.n % 4400, 2);
        p_vs1 = vs1;
        p_fs1 = fs1;
      end
    end
  end

  task automatic run(int cycles, int next_mode);
    repeat (cycles) @(posedge clk);
    #2 mode = next_mode;
  endtask

  initial begin
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        fbmem[y][x] = 4'($urandom);

    rst  = 1'b1;
    mode = 0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;

    run(2600, 1);
    run(1500, 2);
    run(4200, 2);
    // Full-timing DUT is now at hcnt=300, vcnt=10: reset for one cycle
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    mode = $urandom_range(0, 1);

    run(900, 0);
    run(2500, 2);
    run(2000, 1);
    run(600, 0);
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_vga_scan_ctrl
`default_nettype wire
